// File: rtl/serial_adder_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : serial_adder_ctrl (plus leaf half_adder)                     |
// | Description : Bit-serial adder sequencer. A single 1-bit full-adder slice  |
// |               (two half adders + OR) is reused for every bit position of a |
// |               WIDTH-bit add, walking LSB->MSB one bit per clock.           |
// | Config      : SERIAL_ADDER_SUB_EN - adds a 'sub' input; when latched high  |
// |               the block computes in_a - in_b (two's complement).           |
// | Ports       : clk, rst (sync, active-high), start, in_a, in_b,             |
// |               [sub], busy, done, sum, carry_out                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;

  // Operation mode: w_sub_in is the request-side value sampled on accept,
  // w_sub is the value held for the operation in flight.
  logic w_sub_in;
  logic w_sub;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;
  assign w_sub_in = sub;
  assign w_sub    = sub_q;
`else
  assign w_sub_in = 1'b0;
  assign w_sub    = 1'b0;
`endif

  // Shared full-adder slice. Subtraction inverts the B bit going in and
  // seeds the carry with 1 at accept time.
  logic w_b_bit, w_s0, w_c0, w_sum_bit, w_c1, w_cout;
  assign w_b_bit = b_q[0] ^ w_sub;

  half_adder u_ha0 (.a(a_q[0]), .b(w_b_bit), .s(w_s0),      .c(w_c0));
  half_adder u_ha1 (.a(w_s0),   .b(carry_q), .s(w_sum_bit), .c(w_c1));
  assign w_cout = w_c0 | w_c1;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d       = sub_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          a_d     = in_a;
          b_d     = in_b;
          res_d   = '0;
          carry_d = w_sub_in;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d   = sub;
`endif
        end
      end
      ST_RUN: begin
        // Result bits enter at the MSB so after WIDTH shifts the LSB result
        // bit has arrived at position 0.
        res_d   = {w_sum_bit, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = w_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d     = ST_DONE;
          sum_d       = {w_sum_bit, res_q[WIDTH-1:1]};
          carry_out_d = w_cout;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_adder_ctrl                                         |
// | Description : Self-checking bench for serial_adder_ctrl. Expected results  |
// |               come from plain integer arithmetic on the captured operands. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;
  localparam int TW    = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             sub_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  int n_vec = 0;
  int n_err = 0;

  // Last completed result as the outside world should see it.
  logic [TW-1:0] prev_res;

  serial_adder_ctrl #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub_sel),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned add into WIDTH+1 bits, or for subtract the
  // difference modulo 2^WIDTH with carry meaning "no borrow".
  function automatic logic [TW-1:0] ref_model(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic s);
    int unsigned ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    if (s) begin
      r = (ia - ib) % (1 << WIDTH);
      return {(ia >= ib) ? 1'b1 : 1'b0, r[WIDTH-1:0]};
    end
    r = ia + ib;
    return r[TW-1:0];
  endfunction

  // Starts one operation from an IDLE or DONE cycle, watches RUN, and
  // checks the done cycle. Returns with the DUT in its DONE cycle.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input logic hold);
    logic [TW-1:0] exp;
    exp     = ref_model(a, b, s);
    start   = 1'b1;
    in_a    = a;
    in_b    = b;
    sub_sel = s;
    tick();  // accepting edge
    if (!hold) start = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      check("run_busy", TW'(busy), TW'(1'b1));
      check("run_done", TW'(done), TW'(1'b0));
      check("run_hold", {carry_out, sum}, prev_res);
      if (hold) begin
        in_a    = WIDTH'($urandom);
        in_b    = WIDTH'($urandom);
        sub_sel = 1'($urandom);
      end
      tick();
    end
    check("done_pulse", TW'(done), TW'(1'b1));
    check("done_busy",  TW'(busy), TW'(1'b0));
    check("result",     {carry_out, sum}, exp);
    prev_res = exp;
    start    = 1'b0;
  endtask

  initial begin
    logic s_rand;
    rst      = 1'b1;
    start    = 1'b0;
    in_a     = '0;
    in_b     = '0;
    sub_sel  = 1'b0;
    prev_res = '0;
    tick();
    tick();
    check("rst_busy", TW'(busy), TW'(1'b0));
    check("rst_done", TW'(done), TW'(1'b0));
    check("rst_res",  {carry_out, sum}, TW'(0));
    rst = 1'b0;

    // Idle with no start must stay idle.
    tick();
    tick();
    check("idle_busy", TW'(busy), TW'(1'b0));
    check("idle_done", TW'(done), TW'(1'b0));

    // Directed adds, including a carry out of the MSB.
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    tick();
    check("done_one_cycle", TW'(done), TW'(1'b0));
    check("idle_after_done", TW'(busy), TW'(1'b0));
    check("result_held", {carry_out, sum}, prev_res);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    tick();

    // start held through RUN with churning operands: result must come from
    // the accepted pair, then restart exactly at the DONE cycle.
    do_op(8'h81, 8'h7F, 1'b0, 1'b1);
    do_op(8'h12, 8'h34, 1'b0, 1'b0);
    tick();

    // Reset four cycles into RUN aborts with no done pulse.
    start = 1'b1;
    in_a  = 8'hC3;
    in_b  = 8'h5D;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pre_rst_busy", TW'(busy), TW'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_res = '0;
    check("abort_busy", TW'(busy), TW'(1'b0));
    check("abort_done", TW'(done), TW'(1'b0));
    check("abort_res",  {carry_out, sum}, TW'(0));
    for (int k = 0; k < WIDTH + 2; k++) begin
      tick();
      check("abort_no_done", TW'(done), TW'(1'b0));
    end
    do_op(8'hC3, 8'h5D, 1'b0, 1'b0);
    tick();

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h01, 1'b1, 1'b0);
    do_op(8'h01, 8'h02, 1'b1, 1'b0);
    do_op(8'h80, 8'h80, 1'b1, 1'b0);
    tick();
`endif

    // Random back-to-back stream.
    for (int v = 0; v < 64; v++) begin
`ifdef SERIAL_ADDER_SUB_EN
      s_rand = 1'($urandom);
`else
      s_rand = 1'b0;
`endif
      do_op(WIDTH'($urandom), WIDTH'($urandom), s_rand, 1'b0);
    end
    tick();
    check("final_idle", TW'(busy | done), TW'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
